// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline2 issue path.
// Holds the instruction word layout, ALU func encodings and the issue FSM state type.
package pipeline_pkg;
  localparam int REG_W  = 4;
  localparam int FUNC_W = 4;
  localparam int ADDR_W = 8;

  localparam logic [FUNC_W-1:0] FUNC_ADD = 4'd0;
  localparam logic [FUNC_W-1:0] FUNC_SUB = 4'd1;
  localparam logic [FUNC_W-1:0] FUNC_MUL = 4'd2;
  localparam logic [FUNC_W-1:0] FUNC_SLA = 4'd11;

  typedef struct packed {
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [FUNC_W-1:0] func;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  typedef enum logic [1:0] {IDLE, RUN, STALL, FLUSH} issue_state_t;
endpackage

// File: rtl/issue_fifo.sv
// Synchronous instruction FIFO (instr_t entries) feeding the issue scheduler.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr           synchronous clear; wins over push/pop in the same cycle
//   push, din     write one entry (ignored when full)
//   pop, dout     dout is the head entry; pop advances it (ignored when empty)
//   full, empty   status
//   count         occupancy, clog2(DEPTH)+1 bits
module issue_fifo
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic        pop,
  input  instr_t      din,
  output instr_t      dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);
  instr_t        mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;

  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rp];
endmodule

// File: rtl/pipeline_issue_ctrl.sv
// Issue scheduler in front of the 4-stage pipeline2 datapath.
// Buffers instructions, issues at most one per clk and inserts bubbles on
// read-after-write hazards against in-flight destination registers.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready/in_*    instruction source handshake {rs1,rs2,rd,func,addr}
//   flush                     drop buffered, unissued instructions
//   iss_valid/iss_*           registered issue slot (bubble: func=NOP_FUNC, rest 0)
//   stall                     registered: this slot is a hazard bubble
//   busy                      FIFO non-empty or any in-flight rd tracked
// Optional macro PIPE_ISSUE_STATS_EN adds stat_clr, stat_issued, stat_stalls
// (saturating 16-bit counters of iss_valid and stall cycles).
module pipeline_issue_ctrl
  import pipeline_pkg::*;
#(
  parameter int                FIFO_DEPTH = 4,
  parameter int                HAZ_DEPTH  = 2,
  parameter logic [FUNC_W-1:0] NOP_FUNC   = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_rs1,
  input  logic [3:0]  in_rs2,
  input  logic [3:0]  in_rd,
  input  logic [3:0]  in_func,
  input  logic [7:0]  in_addr,
  input  logic        flush,
  output logic        iss_valid,
  output logic [3:0]  iss_rs1,
  output logic [3:0]  iss_rs2,
  output logic [3:0]  iss_rd,
  output logic [3:0]  iss_func,
  output logic [7:0]  iss_addr,
  output logic        stall,
  output logic        busy
`ifdef PIPE_ISSUE_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [15:0] stat_issued,
  output logic [15:0] stat_stalls
`endif
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  issue_state_t                    state;
  instr_t                          in_instr, head;
  logic                            full, empty, push, pop, active, hazard, blocked;
  logic                            sb_any, rdy_en;
  logic [CNT_W-1:0]                count;
  logic [HAZ_DEPTH-1:0]            vld_pipe;
  logic [HAZ_DEPTH-1:0][REG_W-1:0] rd_pipe;

  assign in_instr = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, func: in_func, addr: in_addr};

  // rdy_en keeps in_ready low for the first cycle after reset.
  assign in_ready = rdy_en && !full && (state != FLUSH);
  assign push     = in_valid && in_ready && !flush;
  assign sb_any   = |vld_pipe;
  assign busy     = !empty || sb_any;

  // Head may only be considered once it has sat in the FIFO for a cycle
  // (no bypass); flush overrides the issue decision.
  assign active  = ((state == RUN) || (state == STALL)) && !empty && !flush;
  assign pop     = active && !hazard;
  assign blocked = active && hazard;

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++)
      if (vld_pipe[i] && ((rd_pipe[i] == head.rs1) || (rd_pipe[i] == head.rs2)))
        hazard = 1'b1;
  end

  issue_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (push),
    .pop   (pop),
    .din   (in_instr),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rdy_en    <= 1'b0;
      vld_pipe  <= '0;
      rd_pipe   <= '0;
      iss_valid <= 1'b0;
      iss_rs1   <= '0;
      iss_rs2   <= '0;
      iss_rd    <= '0;
      iss_func  <= NOP_FUNC;
      iss_addr  <= '0;
      stall     <= 1'b0;
    end else begin
      rdy_en <= 1'b1;

      // Scoreboard tracks issued rd until its regbank write is visible.
      vld_pipe[0] <= pop;
      rd_pipe[0]  <= pop ? head.rd : '0;
      for (int i = 1; i < HAZ_DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        rd_pipe[i]  <= rd_pipe[i-1];
      end

      iss_valid <= pop;
      iss_rs1   <= pop ? head.rs1  : '0;
      iss_rs2   <= pop ? head.rs2  : '0;
      iss_rd    <= pop ? head.rd   : '0;
      iss_func  <= pop ? head.func : NOP_FUNC;
      iss_addr  <= pop ? head.addr : '0;
      stall     <= blocked;

      if (flush) state <= FLUSH;
      else begin
        case (state)
          IDLE:  if (push || !empty) state <= RUN;
          RUN, STALL: begin
            if (empty)                                 state <= IDLE;
            else if (hazard)                           state <= STALL;
            else if ((count == CNT_W'(1)) && !push)    state <= IDLE;
            else                                       state <= RUN;
          end
          FLUSH: if (!sb_any) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef PIPE_ISSUE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_issued <= '0;
      stat_stalls <= '0;
    end else begin
      if (iss_valid && (stat_issued != 16'hFFFF)) stat_issued <= stat_issued + 16'd1;
      if (stall && (stat_stalls != 16'hFFFF))     stat_stalls <= stat_stalls + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// Directed bench for pipeline_issue_ctrl: expected instruction words are queued
// on acceptance and popped as the DUT issues; a small regbank model executes
// the issued stream. Define PIPE_ISSUE_STATS_EN to cover the stats counters.
module tb_pipeline_issue_ctrl;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, flush = 1'b0;
  logic [3:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0, in_func = '0;
  logic [7:0]  in_addr = '0;
  logic        iss_valid, stall, busy;
  logic [3:0]  iss_rs1, iss_rs2, iss_rd, iss_func;
  logic [7:0]  iss_addr;
`ifdef PIPE_ISSUE_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_issued, stat_stalls;
`endif

  always #5 clk = ~clk;

  pipeline_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func), .in_addr(in_addr),
    .flush(flush),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_func(iss_func), .iss_addr(iss_addr),
    .stall(stall), .busy(busy)
`ifdef PIPE_ISSUE_STATS_EN
    , .stat_clr(stat_clr), .stat_issued(stat_issued), .stat_stalls(stat_stalls)
`endif
  );

  logic [23:0] exp_q[$];
  logic [7:0]  regs[16];
  int checks = 0, errors = 0, cyc = 0;
  int n_iss = 0, n_stall = 0, first_iss = -1, last_iss = -1, acc_cyc = 0, full_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One clock: sample #1 after the edge, retire issued words against the queue.
  task automatic tick();
    logic [23:0] w, e;
    @(posedge clk); #1;
    cyc++;
    w = {iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr};
    if (iss_valid) begin
      n_iss++;
      if (first_iss < 0) first_iss = cyc;
      last_iss = cyc;
      if (exp_q.size() == 0) chk("spurious_issue", 32'(iss_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("issue_word", 32'(w), 32'(e));
      end
      case (iss_func)
        FUNC_ADD: regs[iss_rd] = regs[iss_rs1] + regs[iss_rs2];
        FUNC_SUB: regs[iss_rd] = regs[iss_rs1] - regs[iss_rs2];
        FUNC_MUL: regs[iss_rd] = regs[iss_rs1] * regs[iss_rs2];
        FUNC_SLA: regs[iss_rd] = regs[iss_rs1] << regs[iss_rs2];
        default: ;
      endcase
    end else
      chk("bubble_fields", 32'(w), 32'h0000F00);
    if (stall) n_stall++;
  endtask

  task automatic send(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                      input logic [3:0] f, input logic [7:0] a);
    int w = 0;
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_func = f; in_addr = a;
    in_valid = 1'b1;
    while (!in_ready && w < 20) begin
      full_seen = 1;
      tick();
      w++;
    end
    if (!in_ready) begin
      chk("send_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back({rs1, rs2, rd, f, a});
    tick();
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic clr_ctrs();
    n_iss = 0; n_stall = 0; first_iss = -1; last_iss = -1; full_seen = 0;
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int a1;
    for (int i = 0; i < 16; i++) regs[i] = 8'(i);

    // Reset state
    tick(); tick();
    chk("rst_iss_valid", 32'(iss_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    tick();
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // 1: independent back-to-back stream
    clr_ctrs();
    send(4'd3, 4'd5, 4'd10, FUNC_ADD, 8'h10);
    a1 = acc_cyc;
    send(4'd3, 4'd8, 4'd12, FUNC_MUL, 8'h11);
    send(4'd7, 4'd3, 4'd13, FUNC_SLA, 8'h12);
    drain(6);
    chk("s1_issued", 32'(n_iss), 32'd3);
    chk("s1_consecutive", 32'(last_iss - first_iss), 32'd2);
    chk("s1_latency", 32'(first_iss - a1), 32'd1);
    chk("s1_stalls", 32'(n_stall), 32'd0);
    chk("s1_r12", 32'(regs[12]), 32'd24);
    chk("s1_r13", 32'(regs[13]), 32'd56);
    chk("s1_busy_idle", 32'(busy), 32'd0);

    // 2: RAW hazard
    clr_ctrs();
    send(4'd3, 4'd5, 4'd10, FUNC_ADD, 8'h20);
    send(4'd10, 4'd5, 4'd14, FUNC_SUB, 8'h21);
    drain(8);
    chk("s2_stalls", 32'(n_stall), 32'd2);
    chk("s2_issued", 32'(n_iss), 32'd2);
    chk("s2_r14", 32'(regs[14]), 32'd3);

    // 3: dependent chain fills the FIFO while the head stalls
    clr_ctrs();
    send(4'd0, 4'd0, 4'd1, FUNC_ADD, 8'h30);
    send(4'd1, 4'd0, 4'd2, FUNC_ADD, 8'h31);
    send(4'd2, 4'd0, 4'd4, FUNC_ADD, 8'h32);
    send(4'd4, 4'd0, 4'd6, FUNC_ADD, 8'h33);
    send(4'd6, 4'd0, 4'd8, FUNC_ADD, 8'h34);
    send(4'd8, 4'd0, 4'd9, FUNC_ADD, 8'h35);
    send(4'd9, 4'd0, 4'd11, FUNC_ADD, 8'h36);
    chk("s3_full_backpressure", 32'(full_seen), 32'd1);
    drain(30);
    chk("s3_issued", 32'(n_iss), 32'd7);
    chk("s3_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("s3_busy_idle", 32'(busy), 32'd0);

    // 4: flush with A,B,C buffered and P in flight (A is independent)
    clr_ctrs();
    send(4'd0, 4'd0, 4'd5, FUNC_ADD, 8'h40);
    send(4'd5, 4'd0, 4'd2, FUNC_ADD, 8'h41);
    send(4'd0, 4'd0, 4'd1, FUNC_ADD, 8'h42);
    send(4'd0, 4'd0, 4'd6, FUNC_ADD, 8'h43);
    send(4'd0, 4'd0, 4'd9, FUNC_ADD, 8'h44);
    chk("s4_pre_flush_queue", 32'(exp_q.size()), 32'd3);
    flush = 1'b1;
    exp_q.delete();
    tick();
    flush = 1'b0;
    chk("s4_busy_inflight", 32'(busy), 32'd1);
    chk("s4_ready_in_flush", 32'(in_ready), 32'd0);
    tick();
    chk("s4_busy_drained", 32'(busy), 32'd0);
    chk("s4_ready_still_flush", 32'(in_ready), 32'd0);
    tick();
    chk("s4_ready_idle", 32'(in_ready), 32'd1);
    clr_ctrs();
    drain(4);
    chk("s4_no_issue_after_flush", 32'(n_iss), 32'd0);
    send(4'd0, 4'd0, 4'd9, FUNC_ADD, 8'h45);
    drain(4);
    chk("s4_fresh_issue", 32'(n_iss), 32'd1);

    // 5: reset during STALL
    clr_ctrs();
    send(4'd0, 4'd0, 4'd7, FUNC_ADD, 8'h50);
    send(4'd7, 4'd0, 4'd8, FUNC_ADD, 8'h51);
    tick();
    chk("s5_in_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    chk("s5_rst_iss_valid", 32'(iss_valid), 32'd0);
    chk("s5_rst_func", 32'(iss_func), 32'hF);
    chk("s5_rst_busy", 32'(busy), 32'd0);
    chk("s5_rst_ready", 32'(in_ready), 32'd0);
    chk("s5_rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    tick();
    chk("s5_ready_back", 32'(in_ready), 32'd1);
    clr_ctrs();
    drain(5);
    chk("s5_no_issue", 32'(n_iss), 32'd0);

`ifdef PIPE_ISSUE_STATS_EN
    // 6: stats over the RAW scenario
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    clr_ctrs();
    send(4'd3, 4'd5, 4'd10, FUNC_ADD, 8'h60);
    send(4'd10, 4'd5, 4'd14, FUNC_SUB, 8'h61);
    drain(8);
    chk("s6_stat_issued", 32'(stat_issued), 32'd2);
    chk("s6_stat_stalls", 32'(stat_stalls), 32'd2);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("s6_clr_issued", 32'(stat_issued), 32'd0);
    chk("s6_clr_stalls", 32'(stat_stalls), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
